// File: rtl/config_frame_pkg.sv
// Shared FSM encoding and header field layout for config_frame_writer.
// FRAME_WRITER_CHECKSUM_EN adds the CHECK state used for the XOR trailer word.
package config_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef FRAME_WRITER_CHECKSUM_EN
    CHECK,
`endif
    STROBE,
    HOLD
  } state_t;

  // Header word: magic byte on top, frame index in the low byte
  localparam logic [7:0]  HdrMagic    = 8'hFA;
  localparam int unsigned HdrMagicMsb = 31;
  localparam int unsigned HdrMagicLsb = 24;
  localparam int unsigned HdrIdxMsb   = 7;
  localparam int unsigned HdrIdxLsb   = 0;
  localparam int unsigned HdrIdxW     = HdrIdxMsb - HdrIdxLsb + 1;

endpackage

// File: rtl/config_frame_writer.sv
// Host-to-fabric configuration frame writer: header, one word per row, one-hot frame strobe.
// Optional FRAME_WRITER_CHECKSUM_EN: trailer word compared against the XOR of the row words.
module config_frame_writer
  import config_frame_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumberOfRows    = 16
) (
  input  logic                                   CLK,
  input  logic                                   resetn,
  input  logic [FrameBitsPerRow-1:0]             WriteData,
  input  logic                                   WriteValid,
  output logic                                   WriteReady,
  output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]             FrameStrobe,
  output logic                                   Busy,
  output logic                                   Error,
  input  logic                                   ErrorClear,
  output logic [15:0]                            FramesDone
);

  localparam int unsigned RowW    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam int unsigned LastRow = NumberOfRows - 1;

  state_t                                          state_q, state_d;
  logic [RowW-1:0]                                 row_q;
  logic [HdrIdxW-1:0]                              idx_q;
  logic [NumberOfRows-1:0][FrameBitsPerRow-1:0]    frame_q;
  logic                                            error_q;
  logic [15:0]                                     done_q;
`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0]                      xor_q;
`endif

  logic accept;
  logic hdr_ok;
  logic last_row;
  logic err_set;

  assign FrameData  = frame_q;
  assign Busy       = (state_q != IDLE);
  assign Error      = error_q;
  assign FramesDone = done_q;

  // Next-state, handshake and strobe decode
  always_comb begin
    state_d     = state_q;
    WriteReady  = 1'b0;
    FrameStrobe = '0;
    err_set     = 1'b0;
    hdr_ok      = (WriteData[HdrMagicMsb:HdrMagicLsb] == HdrMagic) &&
                  (32'(WriteData[HdrIdxMsb:HdrIdxLsb]) < MaxFramesPerCol);
    last_row    = (32'(row_q) == LastRow);
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        WriteReady = 1'b1;
        accept     = WriteValid;
        if (accept) begin
          if (hdr_ok) state_d = DATA;
          else        err_set = 1'b1;
        end
      end
      DATA: begin
        WriteReady = 1'b1;
        accept     = WriteValid;
        if (accept && last_row) begin
`ifdef FRAME_WRITER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = STROBE;
`endif
        end
      end
`ifdef FRAME_WRITER_CHECKSUM_EN
      CHECK: begin
        WriteReady = 1'b1;
        accept     = WriteValid;
        if (accept) begin
          if (WriteData == xor_q) begin
            state_d = STROBE;
          end else begin
            err_set = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      STROBE: begin
        FrameStrobe = MaxFramesPerCol'(1) << idx_q;
        state_d     = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and frame datapath
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      error_q <= 1'b0;
      done_q  <= '0;
`ifdef FRAME_WRITER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;

      // A new error wins over a simultaneous clear
      if (err_set)         error_q <= 1'b1;
      else if (ErrorClear) error_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (accept && hdr_ok) begin
            idx_q <= WriteData[HdrIdxMsb:HdrIdxLsb];
            row_q <= '0;
`ifdef FRAME_WRITER_CHECKSUM_EN
            xor_q <= '0;
`endif
          end
        end
        DATA: begin
          if (accept) begin
            frame_q[row_q] <= WriteData;
            row_q          <= last_row ? '0 : RowW'(row_q + 1'b1);
`ifdef FRAME_WRITER_CHECKSUM_EN
            xor_q          <= xor_q ^ WriteData;
`endif
          end
        end
        STROBE:  done_q <= done_q + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// Scoreboard bench for config_frame_writer; frames are queued when sent and checked at the strobe.
// Also exercises the FRAME_WRITER_CHECKSUM_EN trailer path when that macro is defined.
module tb_config_frame_writer;

  localparam int unsigned Frames = 20;
  localparam int unsigned Bits   = 32;
  localparam int unsigned Rows   = 16;
  localparam int unsigned FlatW  = Bits * Rows;

  logic              CLK        = 1'b0;
  logic              resetn     = 1'b0;
  logic [Bits-1:0]   WriteData  = '0;
  logic              WriteValid = 1'b0;
  logic              WriteReady;
  logic [FlatW-1:0]  FrameData;
  logic [Frames-1:0] FrameStrobe;
  logic              Busy;
  logic              Error;
  logic              ErrorClear = 1'b0;
  logic [15:0]       FramesDone;

  config_frame_writer #(
    .MaxFramesPerCol(Frames),
    .FrameBitsPerRow(Bits),
    .NumberOfRows   (Rows)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .WriteData  (WriteData),
    .WriteValid (WriteValid),
    .WriteReady (WriteReady),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .Busy       (Busy),
    .Error      (Error),
    .ErrorClear (ErrorClear),
    .FramesDone (FramesDone)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]       idx;
    logic [FlatW-1:0] data;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  int               n_checks = 0;
  int               n_fail   = 0;
  int               strobe_seen = 0;
  int               exp_done = 0;
  logic [FlatW-1:0] model_frame = '0;
  logic [Frames-1:0] prev_strobe = '0;
  logic [Frames-1:0] one_hot;

  // Strobe monitor: pops the scoreboard and checks index, contents, width and handshake
  always @(negedge CLK) begin
    if (resetn && FrameStrobe != '0) begin
      strobe_seen++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: FrameStrobe=%h, required no strobe", FrameStrobe);
      end else begin
        mon_e   = sb_q.pop_front();
        one_hot = Frames'(1) << mon_e.idx;
        if (FrameStrobe !== one_hot) begin
          n_fail++;
          $display("FAIL strobe_index: FrameStrobe=%h, required %h", FrameStrobe, one_hot);
        end
        n_checks++;
        if (FrameData !== mon_e.data) begin
          n_fail++;
          $display("FAIL strobe_data: FrameData=%h, required %h", FrameData, mon_e.data);
        end
      end
      n_checks++;
      if (WriteReady !== 1'b0) begin
        n_fail++;
        $display("FAIL strobe_ready: WriteReady=%b, required 0", WriteReady);
      end
      n_checks++;
      if (prev_strobe !== '0) begin
        n_fail++;
        $display("FAIL strobe_width: strobe high on consecutive cycles, previous=%h", prev_strobe);
      end
    end
    prev_strobe = FrameStrobe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    WriteValid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  // Holds WriteValid until accepted; returns one step after the accepting edge
  task automatic send_word(input logic [31:0] w, output int waits);
    waits = 0;
    WriteData  = w;
    WriteValid = 1'b1;
    @(negedge CLK);
    while (!WriteReady && waits < 20) begin
      @(posedge CLK); #1;
      waits++;
      @(negedge CLK);
    end
    if (!WriteReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: WriteReady=%b after %0d cycles, required 1", WriteReady, waits);
    end
    @(posedge CLK); #1;
  endtask

  task automatic send_frame(input logic [7:0] idx, input logic [31:0] base,
                            input bit drop_valid, output int hdr_waits);
    logic [FlatW-1:0] v;
    logic [31:0]      x;
    int               w;
    x = '0;
    for (int k = 0; k < Rows; k++) begin
      v[k*Bits +: Bits] = base + 32'(k);
      x = x ^ (base + 32'(k));
    end
    sb_q.push_back('{idx, v});
    exp_done++;
    send_word({8'hFA, 16'h0000, idx}, hdr_waits);
    for (int k = 0; k < Rows; k++) send_word(base + 32'(k), w);
`ifdef FRAME_WRITER_CHECKSUM_EN
    send_word(x, w);
`endif
    model_frame = v;
    if (drop_valid) WriteValid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (WriteReady !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: WriteReady=%b Busy=%b, required 1 0", WriteReady, Busy);
    end
    n_checks++;
    if (FrameData !== '0 || FrameStrobe !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: FrameData=%h FrameStrobe=%h, required 0", FrameData, FrameStrobe);
    end
    n_checks++;
    if (Error !== 1'b0 || FramesDone !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_status: Error=%b FramesDone=%0d, required 0 0", Error, FramesDone);
    end
    @(posedge CLK); #1;
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic test_basic_frame();
    int w;
    send_frame(8'd3, 32'd0, 1'b1, w);
    n_checks++;
    if (FrameStrobe !== 20'h00008) begin
      n_fail++;
      $display("FAIL basic_strobe_latency: FrameStrobe=%h, required 00008", FrameStrobe);
    end
    n_checks++;
    if (FrameData[5*Bits +: Bits] !== 32'd5) begin
      n_fail++;
      $display("FAIL basic_row5: row5=%h, required 5", FrameData[5*Bits +: Bits]);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (FrameStrobe !== '0 || WriteReady !== 1'b0 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_hold: FrameStrobe=%h WriteReady=%b Busy=%b, required 0 0 1",
               FrameStrobe, WriteReady, Busy);
    end
    n_checks++;
    if (FramesDone !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_frames_done: FramesDone=%0d, required 1", FramesDone);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (WriteReady !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_return_idle: WriteReady=%b Busy=%b, required 1 0", WriteReady, Busy);
    end
  endtask

  task automatic test_bad_header();
    int w;
    int s0;
    s0 = strobe_seen;
    send_word(32'h12000001, w);
    WriteValid = 1'b0;
    n_checks++;
    if (Error !== 1'b1 || Busy !== 1'b0 || FrameStrobe !== '0) begin
      n_fail++;
      $display("FAIL bad_header: Error=%b Busy=%b FrameStrobe=%h, required 1 0 0", Error, Busy, FrameStrobe);
    end
    idle(2);
    n_checks++;
    if (strobe_seen !== s0) begin
      n_fail++;
      $display("FAIL bad_header_strobe: strobes=%0d, required %0d", strobe_seen, s0);
    end
    ErrorClear = 1'b1;
    @(posedge CLK); #1;
    ErrorClear = 1'b0;
    n_checks++;
    if (Error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: Error=%b, required 0", Error);
    end
    ErrorClear = 1'b1;
    send_word(32'h12000001, w);
    WriteValid = 1'b0;
    ErrorClear = 1'b0;
    n_checks++;
    if (Error !== 1'b1) begin
      n_fail++;
      $display("FAIL error_clear_collision: Error=%b, required 1", Error);
    end
    ErrorClear = 1'b1;
    idle(1);
    ErrorClear = 1'b0;
    send_frame(8'd0, 32'h0000_0100, 1'b1, w);
    idle(2);
    n_checks++;
    if (FramesDone !== 16'(exp_done) || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_header_recover: FramesDone=%0d Error=%b, required %0d 0", FramesDone, Error, exp_done);
    end
  endtask

  task automatic test_out_of_range();
    int w;
    int s0;
    s0 = strobe_seen;
    send_word(32'hFA000014, w);
    WriteValid = 1'b0;
    n_checks++;
    if (Error !== 1'b1 || Busy !== 1'b0 || FrameStrobe !== '0) begin
      n_fail++;
      $display("FAIL index_out_of_range: Error=%b Busy=%b FrameStrobe=%h, required 1 0 0", Error, Busy, FrameStrobe);
    end
    idle(2);
    n_checks++;
    if (strobe_seen !== s0 || FramesDone !== 16'(exp_done)) begin
      n_fail++;
      $display("FAIL index_out_of_range_drop: strobes=%0d FramesDone=%0d, required %0d %0d",
               strobe_seen, FramesDone, s0, exp_done);
    end
    ErrorClear = 1'b1;
    idle(1);
    ErrorClear = 1'b0;
    send_frame(8'd19, 32'hA000_0000, 1'b1, w);
    n_checks++;
    if (FrameStrobe !== 20'h80000) begin
      n_fail++;
      $display("FAIL index_max: FrameStrobe=%h, required 80000", FrameStrobe);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int w1;
    int w2;
    send_frame(8'd5, 32'h0000_2000, 1'b0, w1);
    send_frame(8'd6, 32'h0000_3000, 1'b1, w2);
    n_checks++;
    if (w1 !== 0 || w2 !== 2) begin
      n_fail++;
      $display("FAIL back_to_back_stall: header waits=%0d,%0d, required 0,2", w1, w2);
    end
    idle(2);
    n_checks++;
    if (FramesDone !== 16'(exp_done) || sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL back_to_back_count: FramesDone=%0d pending=%0d, required %0d 0",
               FramesDone, sb_q.size(), exp_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    int s0;
    logic [FlatW-1:0] partial;
    partial = model_frame;
    send_word(32'hFA000002, w);
    for (int k = 0; k < 7; k++) begin
      send_word(32'h0000_4000 + 32'(k), w);
      partial[k*Bits +: Bits] = 32'h0000_4000 + 32'(k);
    end
    WriteValid = 1'b0;
    n_checks++;
    if (FrameData !== partial || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_rows_kept: FrameData=%h Busy=%b, required %h 1", FrameData, Busy, partial);
    end
    s0 = strobe_seen;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (FrameData !== '0 || Busy !== 1'b0 || FrameStrobe !== '0 || FramesDone !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: FrameData=%h Busy=%b FrameStrobe=%h FramesDone=%0d, required 0 0 0 0",
               FrameData, Busy, FrameStrobe, FramesDone);
    end
    exp_done    = 0;
    model_frame = '0;
    @(posedge CLK); #1;
    resetn = 1'b1;
    idle(2);
    n_checks++;
    if (strobe_seen !== s0) begin
      n_fail++;
      $display("FAIL reset_mid_frame_strobe: strobes=%0d, required %0d", strobe_seen, s0);
    end
    send_frame(8'd8, 32'h0000_5000, 1'b1, w);
    idle(2);
    n_checks++;
    if (FramesDone !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_recover: FramesDone=%0d, required 1", FramesDone);
    end
  endtask

`ifdef FRAME_WRITER_CHECKSUM_EN
  task automatic test_checksum();
    int w;
    int s0;
    logic [31:0] x;
    s0 = strobe_seen;
    x  = '0;
    send_word(32'hFA000004, w);
    for (int k = 0; k < Rows; k++) begin
      send_word(32'h0000_6000 + 32'(k), w);
      x = x ^ (32'h0000_6000 + 32'(k));
    end
    send_word(x ^ 32'h1, w);
    WriteValid = 1'b0;
    n_checks++;
    if (Error !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL checksum_bad: Error=%b Busy=%b, required 1 0", Error, Busy);
    end
    idle(2);
    n_checks++;
    if (strobe_seen !== s0 || FramesDone !== 16'(exp_done)) begin
      n_fail++;
      $display("FAIL checksum_bad_nostrobe: strobes=%0d FramesDone=%0d, required %0d %0d",
               strobe_seen, FramesDone, s0, exp_done);
    end
    ErrorClear = 1'b1;
    idle(1);
    ErrorClear = 1'b0;
    send_frame(8'd4, 32'h0000_7000, 1'b1, w);
    idle(2);
    n_checks++;
    if (FramesDone !== 16'(exp_done) || Error !== 1'b0) begin
      n_fail++;
      $display("FAIL checksum_good: FramesDone=%0d Error=%b, required %0d 0", FramesDone, Error, exp_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_header();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef FRAME_WRITER_CHECKSUM_EN
    test_checksum();
`endif
    n_checks++;
    if (sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
